// File: rtl/bit_word_generator_if.sv
// Command and word handshakes of the bit word generator.
// master is the generator side; slave is the command source and word consumer.
interface bit_word_generator_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_count;
  logic              cmd_polarity;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              ready_out;

  modport master (
    input  cmd_valid, cmd_count, cmd_polarity, ready_out,
    output cmd_ready, valid_out, data_out
  );

  modport slave (
    output cmd_valid, cmd_count, cmd_polarity, ready_out,
    input  cmd_ready, valid_out, data_out
  );
endinterface

// File: rtl/bit_word_generator.sv
// Builds a word whose bit 0 is P and whose low N upper bits also equal P, one bit per clock,
// then offers it on a valid/ready output.
module bit_word_generator #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  bit_word_generator_if.master  bus,
  output logic [7:0]            words_sent,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBuild = 2'd1,
    StSend  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pol_q, pol_d;
  logic [DATA_W-1:0] build_q, build_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        words_q, words_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pol_q   <= 1'b0;
      build_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      build_q <= build_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    build_d = build_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    words_d = words_q;

    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          cnt_d      = bus.cmd_count;
          pol_d      = bus.cmd_polarity;
          build_d    = '0;
          build_d[0] = bus.cmd_polarity;
          idx_d      = CNT_W'(1);
          state_d    = StBuild;
        end
      end
      StBuild: begin
        build_d[idx_q] = (idx_q <= cnt_q) ? pol_q : ~pol_q;
        idx_d          = idx_q + CNT_W'(1);
        // Publish the word on the same edge that writes its top bit.
        if (idx_q == LastIdx) begin
          data_d  = build_d;
          valid_d = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus.ready_out) begin
          valid_d = 1'b0;
          data_d  = '0;
          words_d = words_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        data_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign words_sent    = words_q;
  assign state_out     = state_q;

endmodule
